// File: rtl/led_counter_pkg.sv
// ----------------------------------------------------------------------------
// led_counter_pkg
//   Shared definitions for the LED up/down counter slice.
//   - MODE_* : encodings of the 2-bit mode input (2'b11 behaves as HOLD)
//   - pc_width(): prescaler counter width, $clog2(PRESCALE) with a floor of 1
//     so that PRESCALE values of 1 and 2 still get a legal 1-bit counter.
// ----------------------------------------------------------------------------
package led_counter_pkg;

  localparam logic [1:0] MODE_DIR    = 2'b00;
  localparam logic [1:0] MODE_BOUNCE = 2'b01;
  localparam logic [1:0] MODE_HOLD   = 2'b10;

  function automatic int pc_width(input int prescale);
    int w;
    w = $clog2(prescale);
    return (w < 1) ? 1 : w;
  endfunction

  // True when the mode lets a prescaler tick move the count.
  function automatic logic mode_steps(input logic [1:0] mode);
    return (mode == MODE_DIR) || (mode == MODE_BOUNCE);
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// ----------------------------------------------------------------------------
// tick_prescaler
//   Divides the enabled clock down to one tick every PRESCALE enabled cycles.
//   Ports:
//     clk   in  clock
//     rst   in  asynchronous active-high reset, counter -> 0
//     en    in  counter advances only while high; tick is forced low when 0
//     clr   in  synchronous clear, restarts the PRESCALE-cycle window
//     tick  out combinational, high on the last enabled cycle of a window
// ----------------------------------------------------------------------------
module tick_prescaler
  import led_counter_pkg::*;
#(
  parameter int PRESCALE = 12_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int              PC_W    = pc_width(PRESCALE);
  localparam logic [PC_W-1:0] PC_LAST = PC_W'(PRESCALE - 1);

  logic [PC_W-1:0] pc;

  // With PRESCALE=1 the counter sits at 0 and tick simply follows en.
  assign tick = en && (pc == PC_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       pc <= '0;
    else if (clr)  pc <= '0;
    else if (tick) pc <= '0;
    else if (en)   pc <= pc + PC_W'(1);
  end

endmodule

// File: rtl/led_updown_counter.sv
// ----------------------------------------------------------------------------
// led_updown_counter
//   Up/down counter driving the board LED bank, stepped by a built-in
//   prescaler. Modes: DIR (direction from up_down), BOUNCE (auto-reversing
//   between 0 and MAX), HOLD. Synchronous load; wrap or saturate in DIR mode.
//   Ports:
//     clk       in  clock
//     rst       in  asynchronous active-high reset
//     en        in  prescaler enable; 0 freezes stepping (load still works)
//     up_down   in  DIR mode direction, 1 = up
//     mode      in  00 DIR, 01 BOUNCE, 10/11 HOLD
//     load      in  synchronous load strobe, beats stepping
//     load_val  in  value loaded on load
//     led       out registered count
//     dir       out registered direction, 1 = up
//     tc        out registered one-cycle pulse on a bound event
// ----------------------------------------------------------------------------
module led_updown_counter
  import led_counter_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 12_000_000,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_down,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] led,
  output logic             dir,
  output logic             tc
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

  logic             tick;
  logic             step;
  logic [WIDTH-1:0] led_nx;
  logic             dir_nx;
  logic             tc_nx;
  logic             at_top;
  logic             at_bot;

  // Load restarts the step window so the first step after a load lands a
  // full PRESCALE enabled cycles later.
  tick_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .clr  (load),
    .tick (tick)
  );

  assign step   = tick && mode_steps(mode);
  assign at_top = (led == CNT_MAX);
  assign at_bot = (led == '0);

  always_comb begin
    led_nx = led;
    dir_nx = dir;
    tc_nx  = 1'b0;
    if (load) begin
      led_nx = load_val;
    end else if (mode == MODE_DIR) begin
      // dir tracks the switch every cycle, so the step taken on this edge
      // follows the same direction that dir shows afterwards.
      dir_nx = up_down;
      if (step) begin
        if (up_down) begin
          if (at_top) begin
            tc_nx  = 1'b1;
            led_nx = (SATURATE != 0) ? CNT_MAX : '0;
          end else begin
            led_nx = led + CNT_ONE;
          end
        end else begin
          if (at_bot) begin
            tc_nx  = 1'b1;
            led_nx = (SATURATE != 0) ? '0 : CNT_MAX;
          end else begin
            led_nx = led - CNT_ONE;
          end
        end
      end
    end else if (mode == MODE_BOUNCE) begin
      if (step) begin
        if (dir && at_top) begin
          // Reverse at the top and move back one in the same step.
          dir_nx = 1'b0;
          led_nx = led - CNT_ONE;
          tc_nx  = 1'b1;
        end else if (!dir && at_bot) begin
          dir_nx = 1'b1;
          led_nx = led + CNT_ONE;
          tc_nx  = 1'b1;
        end else begin
          led_nx = dir ? (led + CNT_ONE) : (led - CNT_ONE);
          // A 1-bit counter touches a bound on every step.
          tc_nx  = (WIDTH == 1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led <= '0;
      dir <= 1'b1;
      tc  <= 1'b0;
    end else begin
      led <= led_nx;
      dir <= dir_nx;
      tc  <= tc_nx;
    end
  end

endmodule

// File: tb/tb_led_updown_counter.sv
// ----------------------------------------------------------------------------
// tb_led_updown_counter
//   Three counter instances share one set of inputs:
//     u0: WIDTH=4 PRESCALE=4 wrap
//     u1: WIDTH=4 PRESCALE=4 saturate
//     u2: WIDTH=4 PRESCALE=1 wrap
//   Each is tracked by an arithmetic reference model; directed steps are
//   followed by a randomized phase.
// ----------------------------------------------------------------------------
module tb_led_updown_counter;

  localparam int W    = 4;
  localparam int NDUT = 3;
  localparam int SPAN = 1 << W;
  localparam int PS  [NDUT] = '{4, 4, 1};
  localparam int SAT [NDUT] = '{0, 1, 0};

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic         up_down;
  logic [1:0]   mode;
  logic         load;
  logic [W-1:0] load_val;
  logic [W-1:0] led [NDUT];
  logic         dir [NDUT];
  logic         tc  [NDUT];

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    int cnt;
    int pc;
    bit dir;
    bit tc;
  } mst_t;

  mst_t m [NDUT];

  always #5 clk = ~clk;

  led_updown_counter #(.WIDTH(W), .PRESCALE(4), .SATURATE(0)) u0 (
    .clk(clk), .rst(rst), .en(en), .up_down(up_down), .mode(mode),
    .load(load), .load_val(load_val), .led(led[0]), .dir(dir[0]), .tc(tc[0]));
  led_updown_counter #(.WIDTH(W), .PRESCALE(4), .SATURATE(1)) u1 (
    .clk(clk), .rst(rst), .en(en), .up_down(up_down), .mode(mode),
    .load(load), .load_val(load_val), .led(led[1]), .dir(dir[1]), .tc(tc[1]));
  led_updown_counter #(.WIDTH(W), .PRESCALE(1), .SATURATE(0)) u2 (
    .clk(clk), .rst(rst), .en(en), .up_down(up_down), .mode(mode),
    .load(load), .load_val(load_val), .led(led[2]), .dir(dir[2]), .tc(tc[2]));

  function automatic mst_t reset_state();
    mst_t s;
    s.cnt = 0; s.pc = 0; s.dir = 1'b1; s.tc = 1'b0;
    return s;
  endfunction

  // Behavioural rules: one call = one clock edge with the current inputs.
  function automatic mst_t ref_next(mst_t s, int p, int sat);
    mst_t n;
    bit   tick;
    int   nxt;
    n    = s;
    n.tc = 1'b0;
    if (load) begin
      n.cnt = int'(load_val);
      n.pc  = 0;
      return n;
    end
    tick = en && (s.pc == p - 1);
    if (en) n.pc = tick ? 0 : s.pc + 1;
    if (mode == 2'd0) begin
      n.dir = up_down;
      if (tick) begin
        nxt = s.cnt + (up_down ? 1 : -1);
        if (nxt < 0 || nxt >= SPAN) begin
          n.tc  = 1'b1;
          n.cnt = (sat != 0) ? s.cnt : (nxt + SPAN) % SPAN;
        end else begin
          n.cnt = nxt;
        end
      end
    end else if (mode == 2'd1 && tick) begin
      nxt = s.cnt + (s.dir ? 1 : -1);
      if (nxt < 0 || nxt >= SPAN) begin
        n.tc  = 1'b1;
        n.dir = !s.dir;
        n.cnt = s.cnt + (s.dir ? -1 : 1);
      end else begin
        n.cnt = nxt;
      end
    end
    return n;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < NDUT; i++) begin
      chk($sformatf("u%0d_led", i), 32'(led[i]), 32'(m[i].cnt));
      chk($sformatf("u%0d_dir", i), 32'(dir[i]), 32'(m[i].dir));
      chk($sformatf("u%0d_tc", i),  32'(tc[i]),  32'(m[i].tc));
    end
  endtask

  // Advance n edges, update models with the inputs seen at each edge and
  // compare 1 time unit later.
  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      for (int i = 0; i < NDUT; i++)
        m[i] = rst ? reset_state() : ref_next(m[i], PS[i], SAT[i]);
      #1;
      check_all();
    end
  endtask

  task automatic do_load(input logic [W-1:0] v);
    load = 1'b1; load_val = v;
    cyc(1);
    load = 1'b0;
  endtask

  initial begin
    int tc_cnt;
    rst = 1'b1; en = 1'b0; up_down = 1'b1; mode = 2'b00; load = 1'b0; load_val = '0;
    for (int i = 0; i < NDUT; i++) m[i] = reset_state();

    // 1: reset values, DIR up, first step after 4 clocks, wrap 15->0
    cyc(2);
    chk("rst_led", 32'(led[0]), 32'd0);
    chk("rst_dir", 32'(dir[0]), 32'd1);
    chk("rst_tc",  32'(tc[0]),  32'd0);
    rst = 1'b0; en = 1'b1;
    cyc(3);
    chk("t1_pre_step", 32'(led[0]), 32'd0);
    cyc(1);
    chk("t1_first_step", 32'(led[0]), 32'd1);
    cyc(4 * 14);
    chk("t1_at_15", 32'(led[0]), 32'd15);
    cyc(4);
    chk("t1_wrap_led", 32'(led[0]), 32'd0);
    chk("t1_wrap_tc",  32'(tc[0]),  32'd1);
    cyc(1);
    chk("t1_tc_drop",  32'(tc[0]),  32'd0);

    // 2: saturating instance held at 0 going down, then counts up
    do_load(4'd0);
    up_down = 1'b0;
    tc_cnt = 0;
    for (int k = 0; k < 16; k++) begin
      cyc(1);
      if (tc[1]) tc_cnt++;
    end
    chk("t2_sat_led", 32'(led[1]), 32'd0);
    chk("t2_sat_tc_pulses", 32'(tc_cnt), 32'd4);
    up_down = 1'b1;
    cyc(8);
    chk("t2_sat_up", 32'(led[1]), 32'd2);

    // 3: bounce from 14, up_down ignored
    mode = 2'b01;
    do_load(4'd14);
    up_down = 1'b0;
    cyc(4);
    chk("t3_15", 32'(led[0]), 32'd15);
    cyc(4);
    chk("t3_rev_led", 32'(led[0]), 32'd14);
    chk("t3_rev_tc",  32'(tc[0]),  32'd1);
    chk("t3_rev_dir", 32'(dir[0]), 32'd0);
    cyc(4 * 14);
    chk("t3_bottom", 32'(led[0]), 32'd0);
    cyc(4);
    chk("t3_up_led", 32'(led[0]), 32'd1);
    chk("t3_up_tc",  32'(tc[0]),  32'd1);
    chk("t3_up_dir", 32'(dir[0]), 32'd1);

    // 4: load mid-window restarts the prescaler
    mode = 2'b00; up_down = 1'b1;
    do_load(4'd0);
    cyc(2);
    do_load(4'hA);
    chk("t4_load_led", 32'(led[0]), 32'hA);
    chk("t4_load_tc",  32'(tc[0]),  32'd0);
    cyc(3);
    chk("t4_no_early", 32'(led[0]), 32'hA);
    cyc(1);
    chk("t4_step_B",   32'(led[0]), 32'hB);

    // 5: async reset between edges, freeze with en=0, HOLD modes
    cyc(2);
    #2 rst = 1'b1;
    #1;
    for (int i = 0; i < NDUT; i++) begin
      chk($sformatf("t5_async_led%0d", i), 32'(led[i]), 32'd0);
      chk($sformatf("t5_async_dir%0d", i), 32'(dir[i]), 32'd1);
      m[i] = reset_state();
    end
    cyc(1);
    rst = 1'b0; en = 1'b0;
    do_load(4'd5);
    cyc(10);
    chk("t5_frozen", 32'(led[0]), 32'd5);
    en = 1'b1; mode = 2'b10;
    tc_cnt = 0;
    for (int k = 0; k < 12; k++) begin
      cyc(1);
      if (tc[0] || tc[2]) tc_cnt++;
    end
    mode = 2'b11;
    for (int k = 0; k < 8; k++) begin
      cyc(1);
      if (tc[0] || tc[2]) tc_cnt++;
    end
    chk("t5_hold_led", 32'(led[2]), 32'd5);
    chk("t5_hold_tc",  32'(tc_cnt), 32'd0);

    // 6: PRESCALE=1 steps every clock, tc on 15->0
    mode = 2'b00; up_down = 1'b1;
    do_load(4'd14);
    cyc(1);
    chk("t6_15", 32'(led[2]), 32'd15);
    cyc(1);
    chk("t6_wrap_led", 32'(led[2]), 32'd0);
    chk("t6_wrap_tc",  32'(tc[2]),  32'd1);

    // Randomized phase
    for (int k = 0; k < 600; k++) begin
      en       = ($urandom % 8) != 0;
      up_down  = ($urandom % 4) != 0 ? up_down : ~up_down;
      if ($urandom % 20 == 0) mode = 2'($urandom % 4);
      load     = ($urandom % 16) == 0;
      load_val = W'($urandom);
      rst      = ($urandom % 150) == 0;
      cyc(1);
    end
    rst = 1'b0; load = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
